// File: rtl/perf_event_counter_if.sv
// Readout stream of perf_event_counter: one frozen counter word per valid/ready transfer.
interface perf_event_counter_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int IDX_W  = $clog2(NUM_CH + 1)
);
   logic             dout_valid_o;
   logic             dout_ready_i;
   logic [IDX_W-1:0] dout_idx_o;
   logic [CNT_W-1:0] dout_data_o;

   modport master (output dout_valid_o, dout_idx_o, dout_data_o, input dout_ready_i);
   modport slave  (input dout_valid_o, dout_idx_o, dout_data_o, output dout_ready_i);
endinterface

// File: rtl/perf_event_counter.sv
// Performance monitor: run-cycle counter plus NUM_CH event counters with a cycle budget,
// and a snapshot of all counters streamed out over a valid/ready port.
module perf_event_counter_lane #(
   parameter int CNT_W = 32,
   parameter int SAT   = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_ovf
);
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (i_inc) begin
         if (&r_cnt) begin
            r_ovf <= 1'b1;
            r_cnt <= (SAT != 0) ? r_cnt : '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_cnt = r_cnt;
   assign o_ovf = r_ovf;
endmodule

module perf_event_counter #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 150,
   parameter int SAT        = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   start_i,
   input  logic [NUM_CH-1:0]      event_i,
   input  logic                   clear_i,
   input  logic                   snap_i,
   perf_event_counter_if.master   dout,
   output logic [CNT_W-1:0]       cycle_o,
   output logic                   done_o,
   output logic [NUM_CH-1:0]      ovf_o
);
   localparam int               IDX_W    = $clog2(NUM_CH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);
   localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} ctl_t;
   typedef enum logic       {R_IDLE, R_STREAM}      rd_t;

   ctl_t                        r_state, w_state_nxt;
   rd_t                         r_rstate, w_rstate_nxt;
   logic                        w_run;
   logic [CNT_W-1:0]            r_cycle, w_cycle_inc;
   logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
   logic [NUM_CH:0][CNT_W-1:0]  r_shadow;
   logic [IDX_W-1:0]            r_idx, w_idx_nxt;
   logic                        w_snap_take, w_xfer;

   // Cycle counter obeys the same saturate/wrap rule as the event lanes.
   always_comb begin
      w_cycle_inc = r_cycle + CNT_W'(1);
      if (&r_cycle) w_cycle_inc = (SAT != 0) ? r_cycle : '0;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run       = 1'b0;
      if (clear_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (start_i) w_state_nxt = S_RUN;
            S_RUN: begin
               w_run = 1'b1;
               if (MAX_CYCLES != 0 && w_cycle_inc == MAX_C) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_cycle <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (clear_i)    r_cycle <= '0;
         else if (w_run) r_cycle <= w_cycle_inc;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      perf_event_counter_lane #(.CNT_W(CNT_W), .SAT(SAT)) u_lane (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .i_clr   (clear_i),
         .i_inc   (w_run && event_i[k]),
         .o_cnt   (w_cnt[k]),
         .o_ovf   (ovf_o[k])
      );
   end

   assign w_xfer = (r_rstate == R_STREAM) && dout.dout_ready_i;

   // Snap is only honoured from R_IDLE, so one arriving with the last transfer is dropped.
   always_comb begin
      w_rstate_nxt = r_rstate;
      w_idx_nxt    = r_idx;
      w_snap_take  = 1'b0;
      case (r_rstate)
         R_IDLE: if (snap_i) begin
            w_snap_take  = 1'b1;
            w_idx_nxt    = '0;
            w_rstate_nxt = R_STREAM;
         end
         R_STREAM: if (w_xfer) begin
            if (r_idx == LAST_IDX) w_rstate_nxt = R_IDLE;
            else                   w_idx_nxt    = r_idx + IDX_W'(1);
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rstate <= R_IDLE;
         r_idx    <= '0;
         r_shadow <= '0;
      end else begin
         r_rstate <= w_rstate_nxt;
         r_idx    <= w_idx_nxt;
         if (w_snap_take) r_shadow <= {r_cycle, w_cnt};
      end
   end

   assign dout.dout_valid_o = (r_rstate == R_STREAM);
   assign dout.dout_idx_o   = r_idx;
   assign dout.dout_data_o  = r_shadow[r_idx];
   assign cycle_o           = r_cycle;
   assign done_o            = (r_state == S_DONE);
endmodule
